wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port between the in-order pipeline writeback (MEM/WB outputs)
//  and one long-latency unit (divider/multi-cycle load) that returns results out of order.
//  Keeps a per-register busy scoreboard of outstanding long-latency destinations for the hazard unit.
//  Forces a pipeline stall when a long-latency result is starved. Sits between WB stage and register file.
// PARAMETERS
//  DATA_WIDTH              32  register data width
//  REG_FILE_ADDRESS_WIDTH  5   register index width; scoreboard has 2**REG_FILE_ADDRESS_WIDTH bits
//  STARVE_LIMIT            4   blocked-cycle count (>=1) before stall is forced
// PORTS
//  clk         in   1    clock, all state on posedge
//  rst_n       in   1    synchronous reset, active-low
//  RegWriteW   in   1    pipeline WB write enable
//  RdW         in   AW   pipeline WB destination
//  ResultW     in   DW   pipeline WB data (post ResultSrcW mux)
//  LuIssue     in   1    long-latency op issued this cycle
//  LuIssueRd   in   AW   its destination
//  LuValid     in   1    long-latency result available
//  LuRd        in   AW   result destination (stable while LuValid && !LuReady)
//  LuData      in   DW   result data (stable while LuValid && !LuReady)
//  LuReady     out  1    result accepted this cycle when LuValid && LuReady
//  RfWE        out  1    register-file write enable
//  RfAddr      out  AW   register-file write address
//  RfWD        out  DW   register-file write data
//  PipeStall   out  1    freeze request to hazard unit; bubble MEM/WB (RegWriteW=0) next cycle
//  Busy        out  2**AW  scoreboard, bit r = long-latency write to xr outstanding
// BEHAVIOUR
//  - pipe_use = RegWriteW && RdW!=0. Pipeline always has priority; it is never delayed or dropped.
//  - LuReady = rst_n && !pipe_use. Handshake hs = LuValid && LuReady. Zero-latency combinational port mux:
//    pipe_use -> RfWE=1,RfAddr=RdW,RfWD=ResultW; else hs && LuRd!=0 -> RfWE=1,RfAddr=LuRd,RfWD=LuData;
//    else RfWE=0, RfAddr=0, RfWD=0.
//  - Writes to x0 are suppressed: RdW==0 never occupies port; LU result with LuRd==0 is accepted, RfWE=0.
//  - FSM (registered) IDLE/WAIT/FORCE, counter cnt width $clog2(STARVE_LIMIT+1), saturating:
//    IDLE: LuValid && !LuReady -> WAIT, cnt=1; else stay, cnt=0.
//    WAIT: hs -> IDLE, cnt=0; blocked && cnt==STARVE_LIMIT-1 -> FORCE; blocked -> cnt+1;
//          LuValid dropped (illegal) -> IDLE.
//    FORCE: hs -> IDLE, cnt=0; else stay. STARVE_LIMIT=1 goes IDLE->FORCE directly.
//  - PipeStall = (state==FORCE) && rst_n (Moore). Pipe write already in WB during FORCE still wins;
//    next-cycle bubble guarantees LU handshake; PipeStall low the cycle after hs.
//  - Scoreboard update at posedge: set Busy[LuIssueRd] if LuIssue && LuIssueRd!=0;
//    clear Busy[LuRd] if hs; set and clear same index same cycle -> set wins. Busy[0] constant 0.
//    Pipeline writes never modify Busy.
//  - Reset (rst_n=0 at posedge): state=IDLE, cnt=0, Busy=0. While rst_n=0: RfWE=0, LuReady=0,
//    PipeStall=0, RfAddr=0, RfWD=0. Reset mid-FORCE/WAIT abandons pending result; LU is reset too.
// TESTING
//  1 rst_n=0 with RegWriteW=1,RdW=5,LuValid=1,LuIssue=1 -> RfWE=0,LuReady=0,PipeStall=0; Busy=0 after edge.
//  2 RegWriteW=1,RdW=3,ResultW=0xAA + LuValid,LuRd=7,LuData=0x55 -> RfAddr=3,RfWD=0xAA,LuReady=0;
//    next cycle RegWriteW=0 -> RfWE=1,RfAddr=7,RfWD=0x55,LuReady=1; state back to IDLE.
//  3 RegWriteW=1,RdW=0 + LuValid,LuRd=9 -> RfAddr=9,LuReady=1; LuValid,LuRd=0 -> LuReady=1,RfWE=0.
//  4 STARVE_LIMIT=4, pipe_use every cycle, LuValid held -> PipeStall=1 after 4 blocked cycles;
//    bench bubbles WB -> LU write occurs; PipeStall=0 next cycle; no pipeline write lost (ref model check).
//  5 LuIssue rd=12 -> Busy[12]=1; hs LuRd=12 with LuIssue rd=12 same cycle -> Busy[12] stays 1;
//    LuIssue rd=0 -> Busy[0]=0; hs LuRd=12 alone -> Busy[12]=0.
//  6 Reach FORCE with Busy[4]=1, assert rst_n=0 one cycle -> PipeStall=0, Busy=0, state IDLE after edge.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the in-order writeback always wins, and a long-latency
// unit returns results out of order into the cycles the pipeline leaves free. It also keeps a busy scoreboard.
module wb_port_arbiter #(
  parameter int DATA_WIDTH             = 32,
  parameter int REG_FILE_ADDRESS_WIDTH = 5,
  parameter int STARVE_LIMIT           = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   RegWriteW,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0]      RdW,
  input  logic [DATA_WIDTH-1:0]                  ResultW,
  input  logic                                   LuIssue,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0]      LuIssueRd,
  input  logic                                   LuValid,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0]      LuRd,
  input  logic [DATA_WIDTH-1:0]                  LuData,
  output logic                                   LuReady,
  output logic                                   RfWE,
  output logic [REG_FILE_ADDRESS_WIDTH-1:0]      RfAddr,
  output logic [DATA_WIDTH-1:0]                  RfWD,
  output logic                                   PipeStall,
  output logic [(2**REG_FILE_ADDRESS_WIDTH)-1:0] Busy
);

  localparam int NUM_REGS = 2 ** REG_FILE_ADDRESS_WIDTH;
  localparam int CNT_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(STARVE_LIMIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_FORCE
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  logic pipe_use;
  logic lu_ready;
  logic hs;
  logic blocked;

  // Port mux. x0 is never written, although an LU result for x0 is still accepted.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    RfWE   = 1'b0;
    RfAddr = '0;
    RfWD   = '0;

    pipe_use = RegWriteW && (RdW != '0);
    lu_ready = rst_n && !pipe_use;
    hs       = LuValid && lu_ready;
    blocked  = LuValid && !lu_ready;

    if (rst_n) begin
      if (pipe_use) begin
        RfWE   = 1'b1;
        RfAddr = RdW;
        RfWD   = ResultW;
      end else if (hs && (LuRd != '0)) begin
        RfWE   = 1'b1;
        RfAddr = LuRd;
        RfWD   = LuData;
      end
    end
  end

  assign LuReady = lu_ready;

  // Starvation tracker: cnt counts consecutive blocked cycles and saturates in FORCE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (blocked) begin
          state_d = (STARVE_LIMIT == 1) ? ST_FORCE : ST_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        if (hs) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (blocked) begin
          if (cnt_q == LAST_WAIT) state_d = ST_FORCE;
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_FORCE: begin
        if (hs) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // The clear is applied before the set, so a re-issue that lands in the same cycle as the retiring result keeps the bit.
  always_comb begin
    busy_d = busy_q;
    if (hs) busy_d[LuRd] = 1'b0;
    if (LuIssue && (LuIssueRd != '0)) busy_d[LuIssueRd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign PipeStall = (state_q == ST_FORCE) && rst_n;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios followed by randomized traffic, all checked
// against a reference model built from blocked-cycle counting, a scoreboard array and register shadows.
module tb_wb_port_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2 ** AW;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          reg_write_w;
  logic [AW-1:0] rd_w;
  logic [DW-1:0] result_w;
  logic          lu_issue;
  logic [AW-1:0] lu_issue_rd;
  logic          lu_valid;
  logic [AW-1:0] lu_rd;
  logic [DW-1:0] lu_data;
  logic          lu_ready;
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_wd;
  logic          pipe_stall;
  logic [NR-1:0] busy;

  wb_port_arbiter #(
    .DATA_WIDTH(DW),
    .REG_FILE_ADDRESS_WIDTH(AW),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteW(reg_write_w), .RdW(rd_w), .ResultW(result_w),
    .LuIssue(lu_issue), .LuIssueRd(lu_issue_rd),
    .LuValid(lu_valid), .LuRd(lu_rd), .LuData(lu_data), .LuReady(lu_ready),
    .RfWE(rf_we), .RfAddr(rf_addr), .RfWD(rf_wd),
    .PipeStall(pipe_stall), .Busy(busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state.
  logic [NR-1:0] m_busy = '0;
  int            m_blk  = 0;
  logic [DW-1:0] m_rf   [NR];
  logic [DW-1:0] dut_rf [NR];
  logic          e_rdy, e_hs, e_stall;
  int            pending[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs are already driven (just after a negedge); settle, then compare against the model.
  task automatic apply_and_check();
    logic          pu;
    logic          ewe;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] ewd;
    #1;
    pu      = reg_write_w && (rd_w != 0);
    e_rdy   = rst_n && !pu;
    e_hs    = lu_valid && e_rdy;
    e_stall = rst_n && (m_blk >= LIMIT);
    ewe = 1'b0; eaddr = '0; ewd = '0;
    if (rst_n && pu) begin
      ewe = 1'b1; eaddr = rd_w; ewd = result_w;
    end else if (e_hs && lu_rd != 0) begin
      ewe = 1'b1; eaddr = lu_rd; ewd = lu_data;
    end
    check("lu_ready", 64'(lu_ready), 64'(e_rdy));
    check("rf_we", 64'(rf_we), 64'(ewe));
    check("rf_addr", 64'(rf_addr), 64'(eaddr));
    check("rf_wd", 64'(rf_wd), 64'(ewd));
    check("pipe_stall", 64'(pipe_stall), 64'(e_stall));
    check("busy", 64'(busy), 64'(m_busy));
    if (ewe) m_rf[eaddr] = ewd;
    if (rf_we === 1'b1) dut_rf[rf_addr] = rf_wd;
  endtask

  // Advance the model across the coming posedge, then wait for the next drive point.
  task automatic advance();
    if (!rst_n) begin
      m_busy = '0;
      m_blk  = 0;
    end else begin
      if (e_hs) m_busy[lu_rd] = 1'b0;
      if (lu_issue && lu_issue_rd != 0) m_busy[lu_issue_rd] = 1'b1;
      m_blk = (lu_valid && !e_rdy) ? m_blk + 1 : 0;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    reg_write_w = 0; rd_w = 0; result_w = 0;
    lu_issue = 0; lu_issue_rd = 0;
    lu_valid = 0; lu_rd = 0; lu_data = 0;
  endtask

  initial begin
    logic bubble;
    int   pct;
    for (int i = 0; i < NR; i++) begin
      m_rf[i] = '0;
      dut_rf[i] = '0;
    end

    // 1: reset masks every output and clears the scoreboard.
    rst_n = 0; idle_inputs();
    reg_write_w = 1; rd_w = 5; result_w = 32'h1234; lu_valid = 1; lu_rd = 6;
    lu_issue = 1; lu_issue_rd = 3;
    apply_and_check();
    check("t1_rf_we", 64'(rf_we), 64'd0);
    check("t1_lu_ready", 64'(lu_ready), 64'd0);
    check("t1_stall", 64'(pipe_stall), 64'd0);
    advance();
    rst_n = 1; idle_inputs();
    apply_and_check();
    check("t1_busy", 64'(busy), 64'd0);
    advance();

    // 2: pipeline wins, the LU result follows in the next free cycle.
    reg_write_w = 1; rd_w = 3; result_w = 32'hAA;
    lu_valid = 1; lu_rd = 7; lu_data = 32'h55;
    apply_and_check();
    check("t2_addr_pipe", 64'(rf_addr), 64'd3);
    check("t2_wd_pipe", 64'(rf_wd), 64'hAA);
    check("t2_ready_lo", 64'(lu_ready), 64'd0);
    advance();
    reg_write_w = 0;
    apply_and_check();
    check("t2_we_lu", 64'(rf_we), 64'd1);
    check("t2_addr_lu", 64'(rf_addr), 64'd7);
    check("t2_wd_lu", 64'(rf_wd), 64'h55);
    check("t2_ready_hi", 64'(lu_ready), 64'd1);
    advance();
    idle_inputs();
    apply_and_check();
    advance();

    // 3: x0 pipeline write leaves the port free; an x0 LU result is accepted without a write.
    reg_write_w = 1; rd_w = 0; result_w = 32'hDEAD;
    lu_valid = 1; lu_rd = 9; lu_data = 32'h99;
    apply_and_check();
    check("t3_addr9", 64'(rf_addr), 64'd9);
    check("t3_ready9", 64'(lu_ready), 64'd1);
    advance();
    lu_rd = 0; lu_data = 32'h77;
    apply_and_check();
    check("t3_ready0", 64'(lu_ready), 64'd1);
    check("t3_we0", 64'(rf_we), 64'd0);
    advance();
    idle_inputs();
    apply_and_check();
    advance();

    // 4: starvation forces a stall after LIMIT blocked cycles; the bubble lets the LU through.
    lu_valid = 1; lu_rd = 11; lu_data = 32'hB0B0;
    for (int i = 0; i < LIMIT; i++) begin
      reg_write_w = 1; rd_w = AW'(i + 1); result_w = $urandom;
      apply_and_check();
      check("t4_no_stall", 64'(pipe_stall), 64'd0);
      advance();
    end
    reg_write_w = 1; rd_w = 13; result_w = $urandom;
    apply_and_check();
    check("t4_stall", 64'(pipe_stall), 64'd1);
    check("t4_pipe_wins", 64'(rf_addr), 64'd13);
    advance();
    reg_write_w = 0;
    apply_and_check();
    check("t4_lu_we", 64'(rf_we), 64'd1);
    check("t4_lu_addr", 64'(rf_addr), 64'd11);
    advance();
    idle_inputs();
    reg_write_w = 1; rd_w = 2; result_w = 32'h22;
    apply_and_check();
    check("t4_stall_gone", 64'(pipe_stall), 64'd0);
    advance();

    // 5: scoreboard set / clear / set-wins / x0 ignored.
    idle_inputs();
    lu_issue = 1; lu_issue_rd = 12;
    apply_and_check();
    advance();
    idle_inputs();
    lu_issue = 1; lu_issue_rd = 12; lu_valid = 1; lu_rd = 12; lu_data = 32'hC;
    apply_and_check();
    check("t5_busy12_set", 64'(busy[12]), 64'd1);
    advance();
    idle_inputs();
    lu_issue = 1; lu_issue_rd = 0;
    apply_and_check();
    check("t5_set_wins", 64'(busy[12]), 64'd1);
    advance();
    idle_inputs();
    lu_valid = 1; lu_rd = 12; lu_data = 32'hC2;
    apply_and_check();
    check("t5_busy0", 64'(busy[0]), 64'd0);
    advance();
    idle_inputs();
    apply_and_check();
    check("t5_busy12_clr", 64'(busy[12]), 64'd0);
    advance();

    // 6: reset in FORCE abandons the pending result and clears everything.
    lu_issue = 1; lu_issue_rd = 4;
    apply_and_check();
    advance();
    idle_inputs();
    lu_valid = 1; lu_rd = 20; lu_data = 32'h2020;
    for (int i = 0; i < LIMIT; i++) begin
      reg_write_w = 1; rd_w = 8; result_w = $urandom;
      apply_and_check();
      advance();
    end
    apply_and_check();
    check("t6_in_force", 64'(pipe_stall), 64'd1);
    check("t6_busy4", 64'(busy[4]), 64'd1);
    advance();
    rst_n = 0;
    apply_and_check();
    check("t6_stall_masked", 64'(pipe_stall), 64'd0);
    advance();
    rst_n = 1; idle_inputs();
    apply_and_check();
    check("t6_stall_after", 64'(pipe_stall), 64'd0);
    check("t6_busy_after", 64'(busy), 64'd0);
    advance();

    // Randomized traffic with an out-of-order LU and a hazard unit that honours the stall.
    bubble = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      pct = (cyc / 500) % 2 == 1 ? 100 : 20 + ((cyc / 500) % 4) * 20;
      if (!rst_n) begin
        rst_n = 1;
        lu_valid = 0;
        pending.delete();
      end else if ($urandom_range(0, 399) == 0) begin
        rst_n = 0;
      end
      reg_write_w = bubble ? 1'b0 : ($urandom_range(0, 99) < pct);
      rd_w        = AW'($urandom_range(0, NR - 1));
      result_w    = $urandom;
      if (!(lu_valid && !e_hs)) begin
        lu_valid = 0;
        if (pending.size() > 0 && $urandom_range(0, 99) < 50) begin
          int idx = $urandom_range(0, pending.size() - 1);
          lu_rd    = AW'(pending[idx]);
          lu_data  = $urandom;
          lu_valid = 1;
          pending.delete(idx);
        end
      end
      lu_issue    = ($urandom_range(0, 99) < 25) && (pending.size() < 8);
      lu_issue_rd = AW'($urandom_range(0, NR - 1));
      if (lu_issue) pending.push_back(int'(lu_issue_rd));
      apply_and_check();
      bubble = e_stall;
      advance();
    end

    // No pipeline or LU write may have been lost or misrouted.
    for (int i = 0; i < NR; i++) check($sformatf("rf_x%0d", i), 64'(dut_rf[i]), 64'(m_rf[i]));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
